// File: rtl/alarm_trigger.sv
// Alarm match detector and ring/snooze/dismiss sequencer driving the ringing, snoozing and buzzer outputs.
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined.
//
// state   | meaning
// IDLE    | alarm disarmed (en=0), all outputs low
// ARMED   | waiting for the clock time to step onto the setpoint
// RINGING | alarm sounding, buzzer blinks once per sec_tick
// SNOOZE  | ring paused, counting down to the next ring (ALARM_SNOOZE_EN only)
module alarm_trigger #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       en,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic [4:0] alm_hr,
    input  logic [5:0] alm_min,
    input  logic       stop,
    input  logic       snooze,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            eq_q, eq_d;
    logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
    logic            ringing_q, ringing_d;
    logic            buzzer_q, buzzer_d;
    logic            rise;

`ifdef ALARM_SNOOZE_EN
    localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_SECS - 1);

    logic [SW-1:0]   snz_cnt_q, snz_cnt_d;
    logic            snoozing_q, snoozing_d;
`else
    logic            unused_snooze;
    assign unused_snooze = snooze;
`endif

    assign eq_d = (cur_hr == alm_hr) && (cur_min == alm_min);
    assign rise = eq_d & ~eq_q;

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        buzzer_d   = buzzer_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        if (!en) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
            buzzer_d   = 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                        buzzer_d   = 1'b1;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        state_d    = ARMED;
                        ring_cnt_d = '0;
                        buzzer_d   = 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_d    = SNOOZE;
                        snz_cnt_d  = '0;
                        ring_cnt_d = '0;
                        buzzer_d   = 1'b0;
`endif
                    end else if (sec_tick) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d    = ARMED;
                            ring_cnt_d = '0;
                            buzzer_d   = 1'b0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + RW'(1);
                            buzzer_d   = ~buzzer_q;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop) begin
                        state_d   = ARMED;
                        snz_cnt_d = '0;
                    end else if (sec_tick) begin
                        if (snz_cnt_q == SNZ_LAST) begin
                            state_d    = RINGING;
                            snz_cnt_d  = '0;
                            ring_cnt_d = '0;
                            buzzer_d   = 1'b1;
                        end else begin
                            snz_cnt_d = snz_cnt_q + SW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_d    = IDLE;
                    ring_cnt_d = '0;
                    buzzer_d   = 1'b0;
                end
            endcase
        end
        ringing_d = (state_d == RINGING);
`ifdef ALARM_SNOOZE_EN
        snoozing_d = (state_d == SNOOZE);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            eq_q       <= 1'b0;
            ring_cnt_q <= '0;
            ringing_q  <= 1'b0;
            buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
            snoozing_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            eq_q       <= eq_d;
            ring_cnt_q <= ring_cnt_d;
            ringing_q  <= ringing_d;
            buzzer_q   <= buzzer_d;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
            snoozing_q <= snoozing_d;
`endif
        end
    end

    assign ringing = ringing_q;
    assign buzzer  = buzzer_q;
`ifdef ALARM_SNOOZE_EN
    assign snoozing = snoozing_q;
`else
    assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: match detection, timeout, stop, snooze, enable and async reset.
module tb_alarm_trigger;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic       en;
    logic [4:0] cur_hr;
    logic [5:0] cur_min;
    logic [4:0] alm_hr;
    logic [5:0] alm_min;
    logic       stop;
    logic       snooze;
    logic       ringing;
    logic       snoozing;
    logic       buzzer;

    int checks = 0;
    int errors = 0;

    alarm_trigger #(.RING_SECS(60), .SNOOZE_SECS(5)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .en(en),
        .cur_hr(cur_hr), .cur_min(cur_min), .alm_hr(alm_hr), .alm_min(alm_min),
        .stop(stop), .snooze(snooze),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic set_cur(input logic [4:0] h, input logic [5:0] m);
        cur_hr  = h;
        cur_min = m;
    endtask

    // From ARMED: move off the setpoint, then onto it.
    task automatic make_ring();
        set_cur(5'd7, 6'd29);
        step();
        set_cur(5'd7, 6'd30);
        step();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({ringing, snoozing, buzzer} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000", {ringing, snoozing, buzzer});
        end
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({ringing, snoozing, buzzer} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle got %b want 000", {ringing, snoozing, buzzer});
        end
    endtask

    task automatic test_ring_timeout();
        en = 1'b1;
        set_cur(5'd7, 6'd29);
        step();
        step();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL armed_no_ring got %b want 0", ringing);
        end
        set_cur(5'd7, 6'd30);
        step();
        checks++;
        if ({ringing, buzzer} !== 2'b11) begin
            errors++;
            $display("FAIL ring_latency got %b want 11", {ringing, buzzer});
        end
        tick();
        checks++;
        if (buzzer !== 1'b0) begin
            errors++;
            $display("FAIL buzzer_tick1 got %b want 0", buzzer);
        end
        tick();
        checks++;
        if (buzzer !== 1'b1) begin
            errors++;
            $display("FAIL buzzer_tick2 got %b want 1", buzzer);
        end
        for (int i = 3; i <= 59; i++) tick();
        checks++;
        if ({ringing, buzzer} !== 2'b10) begin
            errors++;
            $display("FAIL tick59_still_ringing got %b want 10", {ringing, buzzer});
        end
        tick();
        checks++;
        if ({ringing, buzzer} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_tick60 got %b want 00", {ringing, buzzer});
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL no_retrigger_after_timeout got %b want 0", ringing);
        end
    endtask

    task automatic test_stop();
        make_ring();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL stop_setup_ring got %b want 1", ringing);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({ringing, buzzer} !== 2'b00) begin
            errors++;
            $display("FAIL stop_dismiss got %b want 00", {ringing, buzzer});
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL stop_same_minute got %b want 0", ringing);
        end
        make_ring();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL stop_recur_ring got %b want 1", ringing);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_stop_and_snooze();
        make_ring();
        stop   = 1'b1;
        snooze = 1'b1;
        step();
        stop   = 1'b0;
        snooze = 1'b0;
        checks++;
        if ({ringing, snoozing, buzzer} !== 3'b000) begin
            errors++;
            $display("FAIL stop_beats_snooze got %b want 000", {ringing, snoozing, buzzer});
        end
        tick();
        checks++;
        if ({ringing, snoozing} !== 2'b00) begin
            errors++;
            $display("FAIL stop_snooze_settled got %b want 00", {ringing, snoozing});
        end
    endtask

    task automatic test_snooze();
        make_ring();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        checks++;
        if ({ringing, snoozing, buzzer} !== 3'b010) begin
            errors++;
            $display("FAIL snooze_enter got %b want 010", {ringing, snoozing, buzzer});
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({ringing, snoozing} !== 2'b01) begin
            errors++;
            $display("FAIL snooze_tick4 got %b want 01", {ringing, snoozing});
        end
        tick();
        checks++;
        if ({ringing, snoozing, buzzer} !== 3'b101) begin
            errors++;
            $display("FAIL snooze_rering got %b want 101", {ringing, snoozing, buzzer});
        end
        for (int i = 0; i < 59; i++) tick();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL rering_cnt_restart got %b want 1", ringing);
        end
        tick();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL rering_timeout got %b want 0", ringing);
        end
`else
        checks++;
        if ({ringing, snoozing, buzzer} !== 3'b101) begin
            errors++;
            $display("FAIL snooze_ignored got %b want 101", {ringing, snoozing, buzzer});
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL snooze_then_stop got %b want 0", ringing);
        end
`endif
    endtask

    task automatic test_enable();
        en = 1'b0;
        step();
        set_cur(5'd7, 6'd30);
        step();
        en = 1'b1;
        step();
        step();
        step();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL arm_on_match_no_ring got %b want 0", ringing);
        end
        make_ring();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL enable_ring got %b want 1", ringing);
        end
        en = 1'b0;
        step();
        checks++;
        if ({ringing, snoozing, buzzer} !== 3'b000) begin
            errors++;
            $display("FAIL en_drop got %b want 000", {ringing, snoozing, buzzer});
        end
        en = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        make_ring();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup_ring got %b want 1", ringing);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ringing, snoozing, buzzer} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got %b want 000", {ringing, snoozing, buzzer});
        end
        set_cur(5'd7, 6'd29);
        #1;
        rst = 1'b0;
        step();
        step();
        set_cur(5'd7, 6'd30);
        step();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL rst_then_armed got %b want 1", ringing);
        end
    endtask

    initial begin
        rst      = 1'b1;
        sec_tick = 1'b0;
        en       = 1'b0;
        stop     = 1'b0;
        snooze   = 1'b0;
        alm_hr   = 5'd7;
        alm_min  = 6'd30;
        set_cur(5'd0, 6'd0);
        test_reset();
        test_ring_timeout();
        test_stop();
        test_stop_and_snooze();
        test_snooze();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1);
    end

endmodule
